ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 105 ++++++++++
 tb/tb_ram_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Single-port word RAM plus a small MMIO window (COUNT, HALT, SCRATCH) behind one CPU port.
// Every cycle is an access; read data and error status are registered, giving one-cycle latency.
module ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        halt_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [32:0] MMIO_END  = {1'b0, MMIO_BASE} + 33'd16;

  localparam logic [3:0] OFF_COUNT   = 4'h0;
  localparam logic [3:0] OFF_HALT    = 4'h4;
  localparam logic [3:0] OFF_SCRATCH = 4'h8;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        halt_q, halt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] scratch_q, scratch_d;

  logic          aligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic [3:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;

  always_comb begin
    aligned  = (addr_i[1:0] == 2'b00);
    ram_hit  = ({1'b0, addr_i} < RAM_LIMIT);
    mmio_hit = (addr_i >= MMIO_BASE) && ({1'b0, addr_i} < MMIO_END);
    mmio_off = 4'(addr_i - MMIO_BASE);
    ram_idx  = addr_i[AW+1:2];
  end

  // RAM wins if a parameter choice ever overlaps the MMIO window with RAM.
  always_comb begin
    data_d    = '0;
    err_d     = err_q;
    halt_d    = halt_q;
    count_d   = count_q + 32'd1;
    scratch_d = scratch_q;
    ram_we    = 1'b0;
    if (!aligned || !(ram_hit || mmio_hit)) begin
      err_d = 1'b1;
    end else if (ram_hit) begin
      data_d = mem[ram_idx];
      ram_we = we_i;
    end else begin
      case (mmio_off)
        OFF_COUNT: begin
          data_d = count_q;
          if (we_i) count_d = data_i;
        end
        OFF_HALT: begin
          data_d = {31'b0, halt_q};
          if (we_i && data_i[0]) halt_d = 1'b1;
        end
        OFF_SCRATCH: begin
          data_d = scratch_q;
          if (we_i) scratch_d = data_i;
        end
        default: data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      err_q     <= 1'b0;
      halt_q    <= 1'b0;
      count_q   <= '0;
      scratch_q <= '0;
    end else begin
      data_q    <= data_d;
      err_q     <= err_d;
      halt_q    <= halt_d;
      count_q   <= count_d;
      scratch_q <= scratch_d;
    end
  end

  // RAM has no reset, but a write landing on an edge with reset high is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[ram_idx] <= data_i;
  end

  assign data_o = data_q;
  assign err_o  = err_q;
  assign halt_o = halt_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed table-driven bench for ram_responder plus hand sequences for COUNT, errors and reset.
module tb_ram_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] TOP   = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        err;
  logic        halt;

  int passed = 0;
  int total  = 0;

  ram_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .we_i(we), .addr_i(addr), .data_i(din),
    .data_o(dout), .err_o(err), .halt_o(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic [31:0] e, input logic h);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.chk = c; v.exp_data = e; v.exp_err = 1'b0; v.exp_halt = h;
    return v;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 0);
    vecs[1]  = mk(0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 0);
    vecs[2]  = mk(1, 32'h20, 32'h0, 0, 32'h0, 0);
    vecs[3]  = mk(1, 32'h20, 32'h1, 1, 32'h0, 0);
    vecs[4]  = mk(0, 32'h20, 32'h0, 1, 32'h1, 0);
    vecs[5]  = mk(1, 32'h8, 32'hA5A5_A5A5, 0, 32'h0, 0);
    vecs[6]  = mk(0, 32'h8, 32'h0, 1, 32'hA5A5_A5A5, 0);
    vecs[7]  = mk(1, BASE + 8, 32'h1234_5678, 1, 32'h0, 0);
    vecs[8]  = mk(1, BASE + 8, 32'hCAFE_F00D, 1, 32'h1234_5678, 0);
    vecs[9]  = mk(0, BASE + 8, 32'h0, 1, 32'hCAFE_F00D, 0);
    vecs[10] = mk(1, BASE + 12, 32'hFFFF_FFFF, 1, 32'h0, 0);
    vecs[11] = mk(0, BASE + 12, 32'h0, 1, 32'h0, 0);
    vecs[12] = mk(1, BASE + 4, 32'h2, 1, 32'h0, 0);
    vecs[13] = mk(0, BASE + 4, 32'h0, 1, 32'h0, 0);
    vecs[14] = mk(1, BASE + 4, 32'h1, 1, 32'h0, 1);
    vecs[15] = mk(0, BASE + 4, 32'h0, 1, 32'h1, 1);
    vecs[16] = mk(1, 32'h0, 32'h55, 0, 32'h0, 1);
    vecs[17] = mk(0, 32'h0, 32'h0, 1, 32'h55, 1);
    vecs[18] = mk(1, TOP - 4, 32'h77, 0, 32'h0, 1);
    vecs[19] = mk(0, TOP - 4, 32'h0, 1, 32'h77, 1);

    reset = 1'b1; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk32("rst_data", dout, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_halt", halt, 1'b0);

    // First edge after release reads COUNT before its first increment.
    @(negedge clk);
    reset = 1'b0; addr = BASE;
    @(posedge clk);
    #1;
    chk32("count_first", dout, 32'h0);
    access(0, BASE, 32'h0);
    chk32("count_second", dout, 32'h1);

    for (int i = 0; i < 20; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].data);
      if (vecs[i].chk) chk32($sformatf("vec%0d_data", i), dout, vecs[i].exp_data);
      chk1($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      chk1($sformatf("vec%0d_halt", i), halt, vecs[i].exp_halt);
    end

    // COUNT load then wrap.
    access(1, BASE, 32'hFFFF_FFFE);
    access(0, BASE, 32'h0);
    chk32("count_load", dout, 32'hFFFF_FFFE);
    access(0, BASE, 32'h0);
    chk32("count_max", dout, 32'hFFFF_FFFF);
    access(0, BASE, 32'h0);
    chk32("count_wrap", dout, 32'h0);

    // Misaligned write must not touch word 0x10.
    access(1, 32'h12, 32'h9999_9999);
    chk32("misal_data", dout, 32'h0);
    chk1("misal_err", err, 1'b1);
    access(0, 32'h10, 32'h0);
    chk32("misal_ram_kept", dout, 32'hDEAD_BEEF);
    chk1("err_sticky1", err, 1'b1);

    // First unmapped byte above RAM aliases word 0 in the index bits.
    access(1, TOP, 32'h9999_9999);
    chk32("unmap_data", dout, 32'h0);
    chk1("unmap_err", err, 1'b1);
    access(0, 32'h0, 32'h0);
    chk32("unmap_ram_kept", dout, 32'h55);
    access(0, 32'h8000_0000, 32'h0);
    chk32("unmap_hi_data", dout, 32'h0);
    chk1("err_sticky2", err, 1'b1);

    // Asynchronous reset mid-run, with a RAM write pending at the reset edge.
    @(negedge clk);
    we = 1'b1; addr = 32'h8; din = 32'h1111_1111;
    reset = 1'b1;
    #1;
    chk32("arst_data", dout, 32'h0);
    chk1("arst_err", err, 1'b0);
    chk1("arst_halt", halt, 1'b0);
    @(posedge clk);
    #1;
    chk32("arst_hold_data", dout, 32'h0);
    @(negedge clk);
    reset = 1'b0; we = 1'b0; addr = BASE;
    @(posedge clk);
    #1;
    chk32("rel_count0", dout, 32'h0);
    access(0, BASE, 32'h0);
    chk32("rel_count1", dout, 32'h1);
    access(0, 32'h8, 32'h0);
    chk32("ram_retained", dout, 32'hA5A5_A5A5);
    access(0, BASE + 8, 32'h0);
    chk32("scratch_cleared", dout, 32'h0);
    chk1("err_cleared", err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
